// File: rtl/glb_proc_ring_west_bridge.sv
// West-edge bridge of the GLB processor ring: registers processor requests onto the w2e ring
// and returns e2w read responses. Optional read-timeout retire is enabled by GLB_RD_TIMEOUT_EN.
module glb_proc_ring_west_bridge #(
    parameter int unsigned ADDR_W     = 22,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned STRB_W     = 8,
    parameter int unsigned MAX_RD     = 4,
    parameter int unsigned RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              proc_wr_en,
    input  logic [STRB_W-1:0] proc_wr_strb,
    input  logic [ADDR_W-1:0] proc_wr_addr,
    input  logic [DATA_W-1:0] proc_wr_data,
    input  logic              proc_rd_en,
    input  logic [ADDR_W-1:0] proc_rd_addr,
    output logic              proc_ready,
    output logic [DATA_W-1:0] proc_rd_data,
    output logic              proc_rd_data_valid,
    output logic              proc_rd_err,
    output logic              ring_wr_en_w2e,
    output logic [STRB_W-1:0] ring_wr_strb_w2e,
    output logic [ADDR_W-1:0] ring_wr_addr_w2e,
    output logic [DATA_W-1:0] ring_wr_data_w2e,
    output logic              ring_rd_en_w2e,
    output logic [ADDR_W-1:0] ring_rd_addr_w2e,
    input  logic [DATA_W-1:0] ring_rd_data_e2w,
    input  logic              ring_rd_data_valid_e2w
);

    localparam int unsigned CNT_W = $clog2(MAX_RD) + 1;
    localparam logic [CNT_W:0] MAX_RD_C = (CNT_W + 1)'(MAX_RD);

    // Elaboration-time guard against inconsistent parameter sets.
    if (STRB_W != DATA_W / 8 || MAX_RD == 0 || (MAX_RD & (MAX_RD - 1)) != 0 || RD_TIMEOUT == 0)
    begin : g_param_check
        $error("glb_proc_ring_west_bridge: illegal parameter combination");
    end

    logic [CNT_W-1:0] live_cnt_q, live_cnt_d;
    logic [CNT_W-1:0] drop_cnt;
    logic             rd_accept;
    logic             rsp_fwd;
    logic             retire_to;
    logic [DATA_W-1:0] rd_data_d;

`ifdef GLB_RD_TIMEOUT_EN
    localparam int unsigned TIMER_W = $clog2(RD_TIMEOUT + 1);

    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    assign drop_cnt = drop_cnt_q;

    always_comb begin
        drop_cnt_d = drop_cnt_q + CNT_W'(retire_to)
                     - CNT_W'(ring_rd_data_valid_e2w && (drop_cnt_q != '0));
        // Timer measures the age of the oldest live read only.
        if (rsp_fwd || retire_to || (live_cnt_q == '0)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q  <= '0;
            timer_q     <= '0;
            proc_rd_err <= 1'b0;
        end else begin
            drop_cnt_q  <= drop_cnt_d;
            timer_q     <= timer_d;
            proc_rd_err <= retire_to;
        end
    end
`else
    assign drop_cnt    = '0;
    assign proc_rd_err = 1'b0;
`endif

    assign proc_ready = ({1'b0, live_cnt_q} + {1'b0, drop_cnt}) < MAX_RD_C;

    always_comb begin
        rd_accept = proc_rd_en && proc_ready;
        // Responses are in order: timed-out reads' responses arrive first and are swallowed.
        rsp_fwd   = ring_rd_data_valid_e2w && (drop_cnt == '0) && (live_cnt_q != '0);
        retire_to = 1'b0;
`ifdef GLB_RD_TIMEOUT_EN
        retire_to = (live_cnt_q != '0) && !rsp_fwd && (timer_q == TIMER_W'(RD_TIMEOUT));
`endif
        live_cnt_d = live_cnt_q + CNT_W'(rd_accept) - CNT_W'(rsp_fwd) - CNT_W'(retire_to);

        rd_data_d = proc_rd_data;
        if (rsp_fwd) begin
            rd_data_d = ring_rd_data_e2w;
        end else if (retire_to) begin
            rd_data_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_cnt_q         <= '0;
            proc_rd_data       <= '0;
            proc_rd_data_valid <= 1'b0;
            ring_wr_en_w2e     <= 1'b0;
            ring_wr_strb_w2e   <= '0;
            ring_wr_addr_w2e   <= '0;
            ring_wr_data_w2e   <= '0;
            ring_rd_en_w2e     <= 1'b0;
            ring_rd_addr_w2e   <= '0;
        end else begin
            live_cnt_q         <= live_cnt_d;
            proc_rd_data       <= rd_data_d;
            proc_rd_data_valid <= rsp_fwd || retire_to;
            ring_wr_en_w2e     <= proc_wr_en;
            ring_rd_en_w2e     <= rd_accept;
            if (proc_wr_en) begin
                ring_wr_strb_w2e <= proc_wr_strb;
                ring_wr_addr_w2e <= proc_wr_addr;
                ring_wr_data_w2e <= proc_wr_data;
            end
            if (rd_accept) begin
                ring_rd_addr_w2e <= proc_rd_addr;
            end
        end
    end

endmodule

// File: tb/tb_glb_proc_ring_west_bridge.sv
// Self-checking bench for glb_proc_ring_west_bridge: directed test-plan steps then random traffic,
// compared against a count-based reference model. Timeout steps run when GLB_RD_TIMEOUT_EN is set.
module tb_glb_proc_ring_west_bridge;

    localparam int AW = 22;
    localparam int DW = 64;
    localparam int SW = 8;
    localparam int MR = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          proc_wr_en;
    logic [SW-1:0] proc_wr_strb;
    logic [AW-1:0] proc_wr_addr;
    logic [DW-1:0] proc_wr_data;
    logic          proc_rd_en;
    logic [AW-1:0] proc_rd_addr;
    logic          proc_ready;
    logic [DW-1:0] proc_rd_data;
    logic          proc_rd_data_valid;
    logic          proc_rd_err;
    logic          ring_wr_en_w2e;
    logic [SW-1:0] ring_wr_strb_w2e;
    logic [AW-1:0] ring_wr_addr_w2e;
    logic [DW-1:0] ring_wr_data_w2e;
    logic          ring_rd_en_w2e;
    logic [AW-1:0] ring_rd_addr_w2e;
    logic [DW-1:0] ring_rd_data_e2w;
    logic          ring_rd_data_valid_e2w;

    glb_proc_ring_west_bridge #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .STRB_W    (SW),
        .MAX_RD    (MR),
        .RD_TIMEOUT(TO)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .proc_wr_en            (proc_wr_en),
        .proc_wr_strb          (proc_wr_strb),
        .proc_wr_addr          (proc_wr_addr),
        .proc_wr_data          (proc_wr_data),
        .proc_rd_en            (proc_rd_en),
        .proc_rd_addr          (proc_rd_addr),
        .proc_ready            (proc_ready),
        .proc_rd_data          (proc_rd_data),
        .proc_rd_data_valid    (proc_rd_data_valid),
        .proc_rd_err           (proc_rd_err),
        .ring_wr_en_w2e        (ring_wr_en_w2e),
        .ring_wr_strb_w2e      (ring_wr_strb_w2e),
        .ring_wr_addr_w2e      (ring_wr_addr_w2e),
        .ring_wr_data_w2e      (ring_wr_data_w2e),
        .ring_rd_en_w2e        (ring_rd_en_w2e),
        .ring_rd_addr_w2e      (ring_rd_addr_w2e),
        .ring_rd_data_e2w      (ring_rd_data_e2w),
        .ring_rd_data_valid_e2w(ring_rd_data_valid_e2w)
    );

    always #5 clk = ~clk;

    int            n_assert = 0;
    int            n_fail = 0;
    // Reference model: reads awaiting response, reads retired but response still due,
    // age of the oldest live read, last value presented on proc_rd_data.
    int            m_live;
    int            m_drop;
    int            m_age;
    logic [DW-1:0] m_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        proc_wr_en = 1'b0;
        proc_rd_en = 1'b0;
        ring_rd_data_valid_e2w = 1'b0;
        #1;
        chk("rst_ready", proc_ready, 1);
        chk("rst_valid", proc_rd_data_valid, 0);
        chk("rst_err", proc_rd_err, 0);
        chk("rst_data", proc_rd_data, 0);
        chk("rst_ring_wr_en", ring_wr_en_w2e, 0);
        chk("rst_ring_rd_en", ring_rd_en_w2e, 0);
        chk("rst_ring_addr", ring_rd_addr_w2e, 0);
        @(posedge clk);
        #1;
        chk("rst_ready_hold", proc_ready, 1);
        reset = 1'b0;
        m_live = 0;
        m_drop = 0;
        m_age = 0;
        m_data = '0;
    endtask

    // One clock of stimulus; called at posedge+1, returns at the following posedge+1.
    task automatic step(input logic wr, input logic [SW-1:0] strb, input logic [AW-1:0] waddr,
                        input logic [DW-1:0] wdata, input logic rd, input logic [AW-1:0] raddr,
                        input logic rsp, input logic [DW-1:0] rdata);
        bit ready, acc, fwd, e_err;
        int live0;
        ready = (m_live + m_drop) < MR;
        chk("proc_ready", proc_ready, 64'(ready));
        proc_wr_en = wr;
        proc_wr_strb = strb;
        proc_wr_addr = waddr;
        proc_wr_data = wdata;
        proc_rd_en = rd;
        proc_rd_addr = raddr;
        ring_rd_data_valid_e2w = rsp;
        ring_rd_data_e2w = rdata;

        acc = rd && ready;
        fwd = 1'b0;
        e_err = 1'b0;
        live0 = m_live;
        if (rsp) begin
            if (m_drop > 0) begin
                m_drop--;
            end else if (m_live > 0) begin
                fwd = 1'b1;
                m_live--;
                m_data = rdata;
            end
        end
`ifdef GLB_RD_TIMEOUT_EN
        if (!fwd && m_live > 0 && m_age == TO) begin
            e_err = 1'b1;
            m_live--;
            m_drop++;
            m_data = '0;
        end
        m_age = (fwd || e_err || live0 == 0) ? 0 : m_age + 1;
`endif
        if (acc) m_live++;

        @(posedge clk);
        #1;
        chk("ring_wr_en", ring_wr_en_w2e, 64'(wr));
        if (wr) begin
            chk("ring_wr_strb", ring_wr_strb_w2e, strb);
            chk("ring_wr_addr", ring_wr_addr_w2e, waddr);
            chk("ring_wr_data", ring_wr_data_w2e, wdata);
        end
        chk("ring_rd_en", ring_rd_en_w2e, 64'(acc));
        if (acc) chk("ring_rd_addr", ring_rd_addr_w2e, raddr);
        chk("rd_valid", proc_rd_data_valid, 64'(fwd || e_err));
        chk("rd_err", proc_rd_err, 64'(e_err));
        chk("rd_data", proc_rd_data, m_data);
    endtask

    task automatic idle();
        step(0, '0, '0, '0, 0, '0, 0, '0);
    endtask

    task automatic rd_req(input logic [AW-1:0] a);
        step(0, '0, '0, '0, 1, a, 0, '0);
    endtask

    task automatic rsp_ret(input logic [DW-1:0] d);
        step(0, '0, '0, '0, 0, '0, 1, d);
    endtask

    initial begin
        proc_wr_strb = '0;
        proc_wr_addr = '0;
        proc_wr_data = '0;
        proc_rd_addr = '0;
        ring_rd_data_e2w = '0;
        do_reset();

        // Plain write.
        step(1, 8'hFF, 22'h100, 64'hA5A5, 0, '0, 0, '0);
        idle();

        // Single read, response ten cycles later.
        rd_req(22'h200);
        repeat (9) idle();
        rsp_ret(64'h1234);
        idle();

        // Fill to MAX_RD, fifth read refused, one response reopens.
        for (int i = 0; i < 4; i++) rd_req(AW'(22'h300 + i));
        rd_req(22'h304);
        rsp_ret(64'h1111);
        idle();
        rsp_ret(64'h2222);
        rsp_ret(64'h3333);
        rsp_ret(64'h4444);
        idle();

        // Write and read in one packet; response together with a new read.
        step(1, 8'h0F, 22'h10, 64'hCAFE_F00D, 1, 22'h20, 0, '0);
        step(0, '0, '0, '0, 1, 22'h24, 1, 64'h5555);
        rsp_ret(64'h6666);
        // Stray response with nothing outstanding.
        rsp_ret(64'h7777);

`ifdef GLB_RD_TIMEOUT_EN
        // Read that never returns in time; late response swallowed.
        rd_req(22'h400);
        for (int i = 0; i < 18; i++) idle();
        rsp_ret(64'hDEAD);
        idle();
        rd_req(22'h404);
        rsp_ret(64'h8888);
        idle();
`endif

        // Reset with reads in flight; later responses are discarded.
        for (int i = 0; i < 3; i++) rd_req(AW'(22'h500 + i));
        do_reset();
        for (int i = 0; i < 3; i++) rsp_ret(64'hBAD0 + 64'(i));
        idle();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), SW'($urandom), AW'($urandom), {$urandom, $urandom},
                 1'($urandom_range(0, 1)), AW'($urandom), ($urandom_range(0, 2) == 0),
                 {$urandom, $urandom});
        end
        for (int i = 0; i < 12; i++) rsp_ret({$urandom, $urandom});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
